alu_decode_stage: RTL and testbench
===================================

// Module: alu_decode_stage
// PURPOSE
//  Decode stage feeding the ALU. Accepts raw RV32I words on a valid/ready
//  handshake and decodes OP (0110011) and OP-IMM (0010011). Reads rs1/rs2
//  from the register file and emits registered operand_1/operand_2,
//  funct7/funct3 codes and rd to the execute stage.
//  Uses a 2-entry skid buffer, so both handshakes are fully registered.
// PARAMETERS
//  XLEN      32   operand width; must equal the ALU data width
//  REG_AW    5    register address width
// PORTS
//  clk_i          in   1      clock
//  rst_ni         in   1      reset; asynchronous assert, active-low
//  flush_i        in   1      drop all buffered entries
//  in_valid_i     in   1      instr_i is valid
//  in_ready_o     out  1      stage can accept an instruction
//  instr_i        in   32     instruction word
//  rs1_addr_o     out  REG_AW regfile read address 1 = instr_i[19:15]
//  rs2_addr_o     out  REG_AW regfile read address 2 = instr_i[24:20]
//  rs1_data_i     in   XLEN   regfile read data 1 (combinational read)
//  rs2_data_i     in   XLEN   regfile read data 2 (combinational read)
//  out_valid_o    out  1      decoded entry valid
//  out_ready_i    in   1      execute stage accepts the entry
//  operand_1_o    out  XLEN   rs1 value
//  operand_2_o    out  XLEN   rs2 value, or sign-extended imm[11:0]
//  funct7_o       out  alu_funct7_e  NEG or the default code
//  funct3_o       out  alu_funct3_e  ADD/AND/OR/XOR
//  rd_o           out  REG_AW destination register
//  illegal_o      out  1      entry is an unsupported or illegal encoding
// BEHAVIOUR
//  - Reset (rst_ni=0, async): out_valid_o=0, in_ready_o=1, operands=0,
//    rd_o=0, illegal_o=0, funct3_o=ADD, funct7_o=default code, skid empty.
//  - Accept when in_valid_i & in_ready_o at a rising edge.
//    Emit when out_valid_o & out_ready_i at a rising edge.
//  - Latency: 1 cycle from accept to out_valid_o when the output is empty.
//    Full throughput with out_ready_i held high.
//  - in_ready_o is registered: in_ready_o = !skid_full. Output register is
//    the head; skid entry is the tail. Accept while the head is stalled:
//    the entry goes to the skid, then in_ready_o=0 next cycle.
//  - On emit with skid full: skid moves to the head, skid is cleared, and
//    in_ready_o=1 next cycle. Simultaneous accept and emit with skid empty:
//    head is reloaded directly.
//  - Entries are never reordered, duplicated or dropped, except by flush.
//  - Decode, captured at accept time:
//    OP: funct7=0000000 -> default code; 0100000 with funct3=000 -> NEG;
//      anything else -> illegal. operand_2=rs2_data_i.
//    OP-IMM: funct7=default code; operand_2={{20{instr[31]}},instr[31:20]}.
//    funct3: 000=ADD, 100=XOR, 110=OR, 111=AND.
//      001/010/011/101 -> illegal (shifts and compares are not yet in the ALU).
//    Other opcodes -> illegal.
//  - Illegal entries still pass through the pipeline with illegal_o=1,
//    funct3_o=ADD, funct7_o=default code, and operands as read.
//  - rd=x0 is passed through unchanged; execute discards the write.
//  - flush_i: at the next edge, both entries are invalidated and
//    in_ready_o=1. It overrides an accept in the same cycle.
//    Emit in a flush cycle still completes.
//  - Outputs are stable while out_valid_o=1 & out_ready_i=0.
// STRUCTURE
//  - types package: add opcode constants OPC_OP and OPC_OP_IMM, and a
//    decoded_t struct {op1, op2, funct7, funct3, rd, illegal}.
//    Reuse alu_funct7_e and alu_funct3_e unchanged.
//  - Sub-module: alu_decoder (combinational: instr + rs data -> decoded_t).
//    This module owns the skid/handshake logic only.
// TESTING
//  - ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> 1 cycle later: op1=5,
//    op2=7, ADD, default code, rd=3, illegal=0.
//  - SUB 0x402081B3 -> funct7_o=NEG, funct3_o=ADD.
//    ADDI x1,x0,-1 (0xFFF00093) -> op2=0xFFFFFFFF, rd=1.
//  - SLL 0x002091B3 and opcode 0x0000006F -> illegal_o=1, entry still
//    emitted in order.
//  - Stream 4 instrs with out_ready_i low 3 cycles: in_ready_o drops after
//    2 accepts, no loss, order preserved. Throughput = 1/cycle when ready.
//  - flush_i with skid full and in_valid_i=1 -> next cycle out_valid_o=0,
//    in_ready_o=1, flushed instruction never emitted.
//  - rst_ni low mid-stream (async, off-edge) -> outputs at reset values
//    immediately; first accept after release behaves normally.

Source files
------------

// File: rtl/alu_decode_stage_pkg.sv
// Shared types for the ALU decode stage: opcode constants, ALU function
// codes and the decoded entry that travels through the skid buffer.
package alu_decode_stage_pkg;

    // Datapath widths; the stage's XLEN/REG_AW parameters default to these.
    localparam int ALU_XLEN   = 32;
    localparam int ALU_REG_AW = 5;

    // Major opcodes handled by this stage.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct7 codes understood by the ALU.
    typedef enum logic [6:0] {
        F7_DEFAULT = 7'b0000000,
        F7_NEG     = 7'b0100000
    } alu_funct7_e;

    // funct3 codes understood by the ALU.
    typedef enum logic [2:0] {
        F3_ADD = 3'b000,
        F3_XOR = 3'b100,
        F3_OR  = 3'b110,
        F3_AND = 3'b111
    } alu_funct3_e;

    // One decoded instruction as handed to the execute stage.
    typedef struct packed {
        logic [ALU_XLEN-1:0]   op1;
        logic [ALU_XLEN-1:0]   op2;
        alu_funct7_e           funct7;
        alu_funct3_e           funct3;
        logic [ALU_REG_AW-1:0] rd;
        logic                  illegal;
    } decoded_t;

    // True for the funct3 values the ALU currently implements.
    function automatic logic is_alu_funct3(input logic [2:0] funct3);
        return (funct3 == F3_ADD) || (funct3 == F3_XOR) ||
               (funct3 == F3_OR)  || (funct3 == F3_AND);
    endfunction

    // Sign-extend the I-type 12-bit immediate to the datapath width.
    function automatic logic [ALU_XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(ALU_XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_decode_stage_decoder.sv
// Combinational RV32I decoder for OP and OP-IMM: splits out register
// addresses and turns the word plus register read data into a decoded_t.
module alu_decoder
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0]           instr,
    input  logic [ALU_XLEN-1:0]   rs1_data,
    input  logic [ALU_XLEN-1:0]   rs2_data,
    output logic [ALU_REG_AW-1:0] rs1_addr,
    output logic [ALU_REG_AW-1:0] rs2_addr,
    output decoded_t              decoded
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // Decode the instruction; anything not recognised stays illegal with
    // the neutral ADD/default function codes.
    always_comb begin
        // NOTE: every field gets a default first so no path can infer a latch.
        decoded.op1     = rs1_data;
        decoded.op2     = rs2_data;
        decoded.funct7  = F7_DEFAULT;
        decoded.funct3  = F3_ADD;
        decoded.rd      = instr[11:7];
        decoded.illegal = 1'b1;

        unique case (opcode)
            OPC_OP: begin
                if (is_alu_funct3(funct3)) begin
                    if (funct7 == F7_DEFAULT) begin
                        decoded.funct3  = alu_funct3_e'(funct3);
                        decoded.illegal = 1'b0;
                    end else if ((funct7 == F7_NEG) && (funct3 == F3_ADD)) begin
                        decoded.funct7  = F7_NEG;
                        decoded.illegal = 1'b0;
                    end
                end
            end
            OPC_OP_IMM: begin
                // The immediate replaces rs2 even for unsupported funct3.
                decoded.op2 = sext_imm12(instr[31:20]);
                if (is_alu_funct3(funct3)) begin
                    decoded.funct3  = alu_funct3_e'(funct3);
                    decoded.illegal = 1'b0;
                end
            end
            default: begin
                decoded.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage in front of the ALU. Instructions arrive on a valid/ready
// handshake, are decoded at accept time and held in a two-entry skid
// buffer (head = output register, tail = skid) so that both in_ready_o and
// the outputs come straight from flops.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int XLEN   = ALU_XLEN,   // must match the package datapath width
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   operand_1_o,
    output logic [XLEN-1:0]   operand_2_o,
    output alu_funct7_e       funct7_o,
    output alu_funct3_e       funct3_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              illegal_o
);

    decoded_t decoded;
    decoded_t head;
    decoded_t skid;
    logic     head_valid;
    logic     skid_valid;

    logic accept;
    logic emit;
    logic head_load;
    logic skid_fill;
    logic skid_drain;

    alu_decoder u_decoder (
        .instr    (instr_i),
        .rs1_data (rs1_data_i),
        .rs2_data (rs2_data_i),
        .rs1_addr (rs1_addr_o),
        .rs2_addr (rs2_addr_o),
        .decoded  (decoded)
    );

    // Handshake events and buffer moves for this cycle.
    always_comb begin
        accept     = in_valid_i & in_ready_o;
        emit       = head_valid & out_ready_i;
        // The head takes a new entry whenever it is empty or leaving.
        head_load  = emit | ~head_valid;
        // A stalled head pushes the incoming entry into the skid.
        skid_fill  = accept & ~head_load;
        // The skid entry moves forward whenever the head is reloaded.
        skid_drain = head_load & skid_valid;
    end

    // Head/skid state; flush drops both entries, and an emit in the same
    // cycle has already been seen downstream so nothing extra is needed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            // NOTE: payload registers are reset too because the outputs must
            // show zero/ADD/default values while the stage is in reset.
            head       <= '0;
            skid       <= '0;
        end else if (flush_i) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every branch sees last cycle's state.
            if (head_load) begin
                head_valid <= skid_valid | accept;
                if (skid_valid) begin
                    head <= skid;
                end else if (accept) begin
                    head <= decoded;
                end
            end
            if (skid_fill) begin
                skid_valid <= 1'b1;
                skid       <= decoded;
            end else if (skid_drain) begin
                skid_valid <= 1'b0;
            end
        end
    end

    // Ready is a pure function of the skid flop: room exists unless it is full.
    assign in_ready_o  = ~skid_valid;

    assign out_valid_o = head_valid;
    assign operand_1_o = head.op1;
    assign operand_2_o = head.op2;
    assign funct7_o    = head.funct7;
    assign funct3_o    = head.funct3;
    assign rd_o        = head.rd;
    assign illegal_o   = head.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: a queue scoreboard filled on
// accept and drained on emit, plus directed checks of handshake corners.
module tb_alu_decode_stage;
    import alu_decode_stage_pkg::*;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    alu_funct7_e funct7;
    alu_funct3_e funct3;
    logic [4:0]  rd;
    logic        illegal;

    logic [31:0] regs [32];
    exp_t        sb [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    alu_decode_stage dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .instr_i     (instr),
        .rs1_addr_o  (rs1_addr),
        .rs2_addr_o  (rs2_addr),
        .rs1_data_i  (rs1_data),
        .rs2_data_i  (rs2_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .operand_1_o (operand_1),
        .operand_2_o (operand_2),
        .funct7_o    (funct7),
        .funct3_o    (funct3),
        .rd_o        (rd),
        .illegal_o   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference decode, written as a list of the supported instruction forms.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        logic [2:0] f3;
        logic       ok_f3;
        f3    = ins[14:12];
        ok_f3 = (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd6) || (f3 == 3'd7);
        e.op1 = regs[ins[19:15]];
        e.op2 = regs[ins[24:20]];
        e.rd  = ins[11:7];
        e.f7  = 7'h00;
        e.f3  = 3'd0;
        e.ill = 1'b1;
        if (ins[6:0] == 7'h13) begin
            e.op2 = {{20{ins[31]}}, ins[31:20]};
            if (ok_f3) begin
                e.ill = 1'b0;
                e.f3  = f3;
            end
        end else if (ins[6:0] == 7'h33 && ok_f3) begin
            if (ins[31:25] == 7'h00) begin
                e.ill = 1'b0;
                e.f3  = f3;
            end else if (ins[31:25] == 7'h20 && f3 == 3'd0) begin
                e.ill = 1'b0;
                e.f7  = 7'h20;
            end
        end
        return e;
    endfunction

    // Scoreboard: compare on emit, drop on flush/reset, record on accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_emit", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_op1", operand_1, mon_e.op1);
                    check("sb_op2", operand_2, mon_e.op2);
                    check("sb_funct7", funct7, mon_e.f7);
                    check("sb_funct3", funct3, mon_e.f3);
                    check("sb_rd", rd, mon_e.rd);
                    check("sb_illegal", illegal, mon_e.ill);
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(model(instr));
        end
    end

    task automatic send_one(input logic [31:0] w);
        in_valid = 1'b1;
        instr    = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_op1"}, operand_1, 0);
        check({tag, "_op2"}, operand_2, 0);
        check({tag, "_rd"}, rd, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_funct3"}, funct3, F3_ADD);
        check({tag, "_funct7"}, funct7, F7_DEFAULT);
    endtask

    logic [31:0] stall_strm [4];
    logic [31:0] tput_strm  [6];
    int          idx;
    logic        acc;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i * 32'h0000_0101;
        regs[0] = 32'h0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[9] = 32'h8000_00F0;

        stall_strm = '{32'h0020C2B3, 32'h0041E333, 32'h001173B3, 32'h7FF4F413};
        tput_strm  = '{32'h8005C513, 32'h402073B3, 32'h022081B3, 32'h0020C2B3,
                       32'h402081B3, 32'h0041E333};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        out_ready = 1'b1;

        // Reset values while held in reset across a clock edge.
        #8;
        check_reset_values("reset");
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD x3,x1,x2: visible one cycle after accept.
        send_one(32'h002081B3);
        check("add_valid", out_valid, 1);
        check("add_op1", operand_1, 5);
        check("add_op2", operand_2, 7);
        check("add_funct3", funct3, F3_ADD);
        check("add_funct7", funct7, F7_DEFAULT);
        check("add_rd", rd, 3);
        check("add_illegal", illegal, 0);

        send_one(32'h402081B3);
        check("sub_funct7", funct7, F7_NEG);
        check("sub_funct3", funct3, F3_ADD);

        send_one(32'hFFF00093);
        check("addi_op2", operand_2, 32'hFFFF_FFFF);
        check("addi_rd", rd, 1);
        check("addi_illegal", illegal, 0);

        send_one(32'h002091B3);
        check("sll_illegal", illegal, 1);
        check("sll_funct3", funct3, F3_ADD);

        send_one(32'h0000006F);
        check("jal_illegal", illegal, 1);
        check("jal_valid", out_valid, 1);
        @(posedge clk);
        #1;
        check("drain_idle_valid", out_valid, 0);

        // Stream of 4 with the execute stage stalled for 3 cycles.
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            out_ready = (c >= 3);
            in_valid  = 1'b1;
            instr     = stall_strm[idx];
            @(negedge clk);
            acc = in_ready;
            if (c == 2) begin
                check("stall_ready_drop", in_ready, 0);
                check("stall_head_stable", operand_1, regs[5'd1]);
                check("stall_head_rd", rd, 5);
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("stall_accepts", idx, 4);

        // Back-to-back stream at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            instr    = tput_strm[i];
            @(posedge clk);
            #1;
            check("tput_ready", in_ready, 1);
            check("tput_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;

        // Flush with the skid full and a new instruction offered.
        out_ready = 1'b0;
        send_one(32'h0020C2B3);
        send_one(32'h0041E333);
        check("flush_pre_ready", in_ready, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = 32'h001173B3;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_full_valid", out_valid, 0);
        check("flush_full_ready", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("flush_full_stays_empty", out_valid, 0);

        // Flush with emit in the same cycle; the offered entry is dropped.
        out_ready = 1'b0;
        send_one(32'h8005C513);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_emit_valid", out_valid, 0);
        check("flush_emit_ready", in_ready, 1);

        // Asynchronous reset in the middle of a stalled stream.
        out_ready = 1'b0;
        send_one(32'h0020C2B3);
        send_one(32'hFFF00093);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", out_valid, 0);
        send_one(32'h402081B3);
        check("post_rst_accept_valid", out_valid, 1);
        check("post_rst_funct7", funct7, F7_NEG);
        check("post_rst_op1", operand_1, 5);

        // Drain whatever remains, bounded.
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("final_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
